// File: rtl/extint_controller_v2_pkg.sv
// Shared definitions for the external interrupt controller: bus access encoding,
// register offsets and the register selector type.
package extint_controller_v2_pkg;

    localparam int unsigned BUS_ACC_W = 2;
    // Access size is log2(bytes); only full-word accesses are legal.
    localparam logic [BUS_ACC_W-1:0] BUS_ACC_4B = 2'd2;

    localparam int unsigned EIC_PENDING_OFS = 'h0;
    localparam int unsigned EIC_ENABLE_OFS  = 'h4;
    localparam int unsigned EIC_MODE_OFS    = 'h8;
    localparam int unsigned EIC_CLAIM_OFS   = 'hC;

    typedef enum logic [1:0] {
        RegPending = 2'd0,
        RegEnable  = 2'd1,
        RegMode    = 2'd2,
        RegClaim   = 2'd3
    } eic_reg_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eic_prio_enc.sv
// Combinational lowest-index-first priority encoder: request vector to
// {valid, binary index, one-hot winner}.
module eic_prio_enc
    import extint_controller_v2_pkg::*;
#(
    parameter  int unsigned N    = 8,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [IdxW-1:0] idx,
    output logic [N-1:0]    onehot
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid  = |req;
        idx    = '0;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IdxW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/extint_controller_v2.sv
// External interrupt controller with per-source enable, edge/level mode, priority
// and CLAIM register. Define EIC_SYNC_EN to add 2-flop source synchronisers.
module extint_controller_v2
    import extint_controller_v2_pkg::*;
#(
    parameter int unsigned SRC_NUM   = 8,
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 ext_int_trigger,
    input  logic                 ext_int_handled,
    input  logic [SRC_NUM-1:0]   ext_int_src,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 w_rb,
    input  logic [BUS_ACC_W-1:0] acc,
    output logic [BUS_WIDTH-1:0] rdata,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic                 req,
    output logic                 resp,
    output logic                 fault
);

    localparam int unsigned IdxW = idx_width(SRC_NUM);

    logic [SRC_NUM-1:0]   src_s;
    logic [SRC_NUM-1:0]   pend_q, pend_d;
    logic [SRC_NUM-1:0]   en_q, en_d;
    logic [SRC_NUM-1:0]   mode_q, mode_d;
    logic [SRC_NUM-1:0]   hist_q;
    logic [SRC_NUM-1:0]   rise, clr, wsrc;
    logic                 resp_q;
    logic [BUS_WIDTH-1:0] rdata_q, rd_val, claim_val;

    logic                 win_valid;
    logic [IdxW-1:0]      win_idx;
    logic [SRC_NUM-1:0]   win_oh;

    logic                 reg_hit;
    eic_reg_e             reg_sel;
    logic                 illegal, legal, wr_en, rd_en;
    logic                 wr_pend, wr_en_reg, wr_mode;
    logic                 unused_wdata;

`ifdef EIC_SYNC_EN
    logic [SRC_NUM-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ext_int_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = ext_int_src;
`endif

    eic_prio_enc #(
        .N (SRC_NUM)
    ) u_prio_enc (
        .req    (pend_q & en_q),
        .valid  (win_valid),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    // Bus decode
    always_comb begin
        reg_hit = 1'b1;
        reg_sel = RegPending;
        if (addr == ADDR_W'(EIC_PENDING_OFS)) begin
            reg_sel = RegPending;
        end else if (addr == ADDR_W'(EIC_ENABLE_OFS)) begin
            reg_sel = RegEnable;
        end else if (addr == ADDR_W'(EIC_MODE_OFS)) begin
            reg_sel = RegMode;
        end else if (addr == ADDR_W'(EIC_CLAIM_OFS)) begin
            reg_sel = RegClaim;
        end else begin
            reg_hit = 1'b0;
        end
    end

    assign illegal   = (acc != BUS_ACC_4B) || (addr[1:0] != 2'b00)
                     || (w_rb && (addr == ADDR_W'(EIC_CLAIM_OFS)));
    assign fault     = req & illegal;
    assign legal     = req & ~illegal;
    assign wr_en     = legal & w_rb;
    assign rd_en     = legal & ~w_rb;
    assign wr_pend   = wr_en & reg_hit & (reg_sel == RegPending);
    assign wr_en_reg = wr_en & reg_hit & (reg_sel == RegEnable);
    assign wr_mode   = wr_en & reg_hit & (reg_sel == RegMode);

    assign wsrc         = wdata[SRC_NUM-1:0];
    assign unused_wdata = ^wdata;

    // Source tracking
    assign rise = src_s & ~hist_q;
    assign clr  = ({SRC_NUM{wr_pend}} & wsrc) | ({SRC_NUM{ext_int_handled}} & win_oh);

    always_comb begin
        en_d   = wr_en_reg ? wsrc : en_q;
        mode_d = wr_mode ? wsrc : mode_q;
        pend_d = pend_q;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (mode_q[i]) begin
                // Leaving level mode drops the bit; history already tracks src.
                pend_d[i] = (wr_mode && !wsrc[i]) ? 1'b0 : src_s[i];
            end else begin
                pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
            end
        end
    end

    assign claim_val = win_valid ? (BUS_WIDTH'(win_idx) + BUS_WIDTH'(1)) : '0;

    always_comb begin
        rd_val = '0;
        if (reg_hit) begin
            unique case (reg_sel)
                RegPending: rd_val = BUS_WIDTH'(pend_q);
                RegEnable:  rd_val = BUS_WIDTH'(en_q);
                RegMode:    rd_val = BUS_WIDTH'(mode_q);
                RegClaim:   rd_val = claim_val;
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q  <= '0;
            en_q    <= '1;
            mode_q  <= '0;
            hist_q  <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            hist_q <= src_s;
            resp_q <= legal;
            if (rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign ext_int_trigger = |(pend_q & en_q);
    assign resp            = resp_q;
    assign rdata           = rdata_q;

endmodule
